shared_unit_arbiter: RTL and testbench
======================================

# shared_unit_arbiter

Two-requester arbiter sharing one fixed-latency n-bit arithmetic unit (multiplier/adder) in the Runge-Kutta datapath. Registers the winning requester's operands onto the shared unit inputs, drives the operand mux select, tracks the owner of every in-flight operation, and routes each result back to its originator. It sits between the stage-evaluation logic (requesters) and the single shared arithmetic core.

## Interface
Parameters:
- n, 32, operand/result width
- LAT, 4, shared unit latency in cycles (legal 1..16)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  reset, synchronous and active-low
- REQ_0 / REQ_1  input  1  requester has a valid operation; held with operands until its ACK
- A_0, B_0 / A_1, B_1  input  n  operands of requester 0 / 1
- ACK_0 / ACK_1  output  1  one-cycle pulse: operation accepted and issued
- SEL  output  1  operand mux select (0 = requester 0), registered, held between issues
- U_VALID  output  1  issue strobe to shared unit
- U_A, U_B  output  n  registered operands to shared unit
- U_RES  input  n  unit result, valid exactly LAT cycles after matching U_VALID
- RES_VALID_0 / RES_VALID_1  output  1  one-cycle result strobe to requester 0 / 1
- RES  output  n  registered result, shared by both requesters
- PEND  output  5  operations issued but not yet returned (0..LAT)

## Operation
- Reset: ACK_x=0, U_VALID=0, U_A=U_B=0, SEL=0, RES=0, RES_VALID_x=0, PEND=0, tag pipeline cleared, round-robin pointer = requester 0 preferred.
- Eligibility: REQ_x is eligible unless ACK_x=1 in the current cycle (REQ still high from the accepted op is ignored).
- Arbitration each cycle: one eligible → it wins; both eligible → round-robin pointer winner; winner's acceptance moves pointer to the other requester. None eligible → pointer unchanged.
- Issue (next edge after winning): U_VALID=1, U_A/U_B=winner operands, SEL=winner, ACK_winner=1, all for one cycle; SEL keeps its value afterward.
- Tag pipeline: LAT-deep shift register of {valid, owner}; entry inserted on each issue, shifted every cycle.
- Return: tag leaves pipeline in the cycle U_RES is valid; next edge RES=U_RES, RES_VALID_owner=1 for one cycle. RES holds value otherwise.
- PEND: +1 on issue, −1 on return, both same cycle → unchanged. Never exceeds LAT (at most one issue per cycle).
- No back-pressure on results; requester must accept RES_VALID_x when pulsed.
- Reset mid-operation: all in-flight tags dropped; no RES_VALID pulse for operations issued before reset, even if U_RES arrives later.

## Timing
- REQ_x sampled cycle t → ACK_x, U_VALID in cycle t+1.
- U_VALID cycle t+1 → U_RES sampled cycle t+1+LAT → RES_VALID_x cycle t+2+LAT. Request-to-result latency LAT+2.
- Single requester throughput: one op per 2 cycles. Both requesting continuously: unit issues every cycle, alternating 0,1,0,1.
- Issue and return of different requesters in same cycle are independent.

## Configuration
- ARB_FIXED_PRIO_EN defined: requester 0 always wins when both eligible; pointer not used (requester 1 can starve).
- Undefined: round-robin as above.

## Test plan
- Reset: assert RST_N=0 two cycles with REQ_0=1 → all outputs 0, no ACK until first cycle after release; ACK_0 at release+1.
- Single op: REQ_0, A_0=3, B_0=5, unit model multiplies, LAT=4 → ACK_0 at t+1, RES=15 with RES_VALID_0 at t+6, PEND 1 for cycles t+2..t+5 then 0.
- Contention: REQ_0 and REQ_1 held for 8 ops each → U_VALID every cycle, SEL 0,1,0,1…, each result routed to correct RES_VALID_x in issue order.
- Single continuous requester: REQ_1 held 6 ops → ACK_1 every other cycle, PEND never above 3 for LAT=4.
- Reset mid-flight: issue 3 ops, assert reset at PEND=3 → no RES_VALID pulses afterwards, PEND=0.
- ARB_FIXED_PRIO_EN defined, both requesting → ACK_0 every other cycle, ACK_1 only in cycles requester 0 is ineligible.

Source files
------------

// File: rtl/shared_unit_arbiter.sv
// -----------------------------------------------------------------------------
// shared_unit_arbiter
//
// Arbitrates two requesters onto a single fixed-latency n-bit arithmetic unit.
// The winner's operands are registered onto the unit inputs together with an
// issue strobe and the operand mux select. A LAT-deep tag pipeline remembers
// which requester owns every in-flight operation, so the unit result can be
// registered and steered back to its originator.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                      undefined -> round-robin tie break (default)
//
// Parameters:
//   n    operand/result width
//   LAT  shared unit latency in cycles (1..16)
//
// Ports:
//   CLK, RST_N              clock, synchronous active-low reset
//   REQ_x, A_x, B_x         request and operands of requester x, held until ACK_x
//   ACK_x                   one-cycle pulse, operation of requester x issued
//   SEL                     operand mux select of the last issue (0 = requester 0)
//   U_VALID, U_A, U_B       issue strobe and operands to the shared unit
//   U_RES                   unit result, valid LAT cycles after its U_VALID
//   RES_VALID_x, RES        result strobe to requester x, shared result register
//   PEND                    number of operations issued but not yet returned
// -----------------------------------------------------------------------------
module shared_unit_arbiter #(
  parameter int n   = 32,
  parameter int LAT = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         REQ_0,
  input  logic         REQ_1,
  input  logic [n-1:0] A_0,
  input  logic [n-1:0] B_0,
  input  logic [n-1:0] A_1,
  input  logic [n-1:0] B_1,
  output logic         ACK_0,
  output logic         ACK_1,
  output logic         SEL,
  output logic         U_VALID,
  output logic [n-1:0] U_A,
  output logic [n-1:0] U_B,
  input  logic [n-1:0] U_RES,
  output logic         RES_VALID_0,
  output logic         RES_VALID_1,
  output logic [n-1:0] RES,
  output logic [4:0]   PEND
);

  logic [1:0]     ack_reg, ack_next;
  logic           u_valid_reg;
  logic           sel_reg;
  logic [n-1:0]   u_a_reg, u_b_reg, res_reg;
  logic [1:0]     res_valid_reg, res_valid_next;
  logic [4:0]     pend_reg, pend_next;
  logic           elig_0, elig_1, issue, win;
  logic [LAT-1:0] tag_valid_reg, tag_owner_reg;
  logic [LAT-1:0] tag_valid_shift, tag_owner_shift;
  logic           ret_valid, ret_owner;
`ifndef ARB_FIXED_PRIO_EN
  logic           rr_reg;   // requester preferred on the next tie
`endif

  // ---------------------------------------------------------------------------
  // Arbitration. A requester that is being acknowledged this cycle still has
  // REQ high for the operation just accepted, so it sits out one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    elig_0   = REQ_0 & ~ack_reg[0];
    elig_1   = REQ_1 & ~ack_reg[1];
    issue    = elig_0 | elig_1;
`ifdef ARB_FIXED_PRIO_EN
    win      = ~elig_0;
`else
    win      = (elig_0 & elig_1) ? rr_reg : elig_1;
`endif
    ack_next = 2'b00;
    if (issue) begin
      ack_next = win ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ack_reg     <= 2'b00;
      u_valid_reg <= 1'b0;
      sel_reg     <= 1'b0;
      u_a_reg     <= '0;
      u_b_reg     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_reg      <= 1'b0;
`endif
    end else begin
      ack_reg     <= ack_next;
      u_valid_reg <= issue;
      if (issue) begin
        sel_reg <= win;
        u_a_reg <= win ? A_1 : A_0;
        u_b_reg <= win ? B_1 : B_0;
`ifndef ARB_FIXED_PRIO_EN
        rr_reg  <= ~win;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. It is fed from the registered issue strobe/select, so the
  // tag sits in the last stage exactly in the cycle U_RES carries its result.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_shift[gi] = u_valid_reg;
        assign tag_owner_shift[gi] = sel_reg;
      end else begin : g_body
        assign tag_valid_shift[gi] = tag_valid_reg[gi-1];
        assign tag_owner_shift[gi] = tag_owner_reg[gi-1];
      end
    end
  endgenerate

  assign ret_valid = tag_valid_reg[LAT-1];
  assign ret_owner = tag_owner_reg[LAT-1];

  // PEND equals the number of valid tags: one enters per issue strobe and one
  // leaves per return, a simultaneous enter/leave cancels out.
  always_comb begin
    res_valid_next = 2'b00;
    if (ret_valid) begin
      res_valid_next = ret_owner ? 2'b10 : 2'b01;
    end
    pend_next = pend_reg;
    if (u_valid_reg && !ret_valid) begin
      pend_next = pend_reg + 5'd1;
    end else if (!u_valid_reg && ret_valid) begin
      pend_next = pend_reg - 5'd1;
    end
  end

  // Reset drops every tag, so results of operations issued before reset are
  // never reported even though the unit still produces them.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
      res_valid_reg <= 2'b00;
      res_reg       <= '0;
      pend_reg      <= 5'd0;
    end else begin
      tag_valid_reg <= tag_valid_shift;
      tag_owner_reg <= tag_owner_shift;
      res_valid_reg <= res_valid_next;
      pend_reg      <= pend_next;
      if (ret_valid) begin
        res_reg <= U_RES;
      end
    end
  end

  assign ACK_0       = ack_reg[0];
  assign ACK_1       = ack_reg[1];
  assign SEL         = sel_reg;
  assign U_VALID     = u_valid_reg;
  assign U_A         = u_a_reg;
  assign U_B         = u_b_reg;
  assign RES_VALID_0 = res_valid_reg[0];
  assign RES_VALID_1 = res_valid_reg[1];
  assign RES         = res_reg;
  assign PEND        = pend_reg;

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_unit_arbiter
//
// Bench for shared_unit_arbiter with a multiplying unit model of latency LAT.
// Directed vector table (reset, single operations), stream sequences
// (contention, single continuous requester, fixed priority), reset during
// flight, and a randomized run against a cycle-indexed scoreboard model.
// Honours ARB_FIXED_PRIO_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_shared_unit_arbiter;

  localparam int N   = 32;
  localparam int LAT = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, sel, u_valid;
  logic [N-1:0] u_a, u_b, u_res, res;
  logic         rv0, rv1;
  logic [4:0]   pend;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shared_unit_arbiter #(.n(N), .LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_0(req0), .REQ_1(req1),
    .A_0(a0), .B_0(b0), .A_1(a1), .B_1(b1),
    .ACK_0(ack0), .ACK_1(ack1),
    .SEL(sel), .U_VALID(u_valid), .U_A(u_a), .U_B(u_b),
    .U_RES(u_res),
    .RES_VALID_0(rv0), .RES_VALID_1(rv1), .RES(res), .PEND(pend)
  );

  // Shared unit model: multiplier, result valid LAT cycles after U_VALID.
  logic [N-1:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= u_valid ? u_a * u_b : 32'hdead_beef;
    for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
  end
  assign u_res = unit_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for a cycle, outputs seen after that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst_n, r0, r1;
    logic [N-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, uv, sel, rv0, rv1;
    logic [N-1:0] ua, ub, res;
    logic [4:0]   pend;
  } vec_t;

  function automatic vec_t mkv(input logic rs, input logic r0, input logic r1,
                               input int va0, input int vb0, input int va1, input int vb1,
                               input logic k0, input logic k1, input logic uv, input logic s,
                               input logic v0, input logic v1,
                               input int ua, input int ub, input int rr, input int pd);
    vec_t v;
    v.rst_n = rs; v.r0 = r0; v.r1 = r1;
    v.a0 = va0; v.b0 = vb0; v.a1 = va1; v.b1 = vb1;
    v.ack0 = k0; v.ack1 = k1; v.uv = uv; v.sel = s; v.rv0 = v0; v.rv1 = v1;
    v.ua = ua; v.ub = ub; v.res = rr; v.pend = 5'(pd);
    return v;
  endfunction

  localparam int NV = 15;
  vec_t tbl [NV];

  // ---------------------------------------------------------------------------
  // Stream driver: each requester issues a fixed number of operations, keeping
  // REQ high and presenting a new operation right after each ACK.
  // ---------------------------------------------------------------------------
  task automatic run_stream(input int want0, input int want1,
                            output int n_iss, output int span, output int alt_bad,
                            output int gap_bad, output int max_pend);
    logic [N-1:0] exp0 [$];
    logic [N-1:0] exp1 [$];
    int   left0, left1, got0, got1, first_iss, last_iss, last_ack1;
    logic last_sel, prev_req0, prev_ack0;
    left0 = want0; left1 = want1; got0 = 0; got1 = 0;
    n_iss = 0; alt_bad = 0; gap_bad = 0; max_pend = 0;
    first_iss = -1; last_iss = -1; last_ack1 = -1; last_sel = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    if (want0 > 0) begin a0 = $urandom; b0 = $urandom; req0 = 1'b1; exp0.push_back(a0 * b0); end
    if (want1 > 0) begin a1 = $urandom; b1 = $urandom; req1 = 1'b1; exp1.push_back(a1 * b1); end
    prev_req0 = req0; prev_ack0 = ack0;
    for (int cyc = 0; cyc < 300 && (got0 < want0 || got1 < want1); cyc++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      if (ack1) chk("fixed_ack1_while_r0_eligible", prev_req0 & ~prev_ack0, 1'b0);
`endif
      if (u_valid) begin
        if (n_iss > 0 && cyc == last_iss + 1 && sel == last_sel) alt_bad++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc; last_sel = sel; n_iss++;
      end
      if (int'(pend) > max_pend) max_pend = int'(pend);
      if (rv0) begin
        if (exp0.size() == 0) chk("stream_rv0_unexpected", 1'b1, 1'b0);
        else chk("stream_res_r0", res, exp0.pop_front());
        got0++;
      end
      if (rv1) begin
        if (exp1.size() == 0) chk("stream_rv1_unexpected", 1'b1, 1'b0);
        else chk("stream_res_r1", res, exp1.pop_front());
        got1++;
      end
      if (ack1) begin
        if (last_ack1 >= 0 && cyc - last_ack1 != 2) gap_bad++;
        last_ack1 = cyc;
      end
      if (ack0) begin
        left0--;
        if (left0 > 0) begin a0 = $urandom; b0 = $urandom; exp0.push_back(a0 * b0); end
        else req0 = 1'b0;
      end
      if (ack1) begin
        left1--;
        if (left1 > 0) begin a1 = $urandom; b1 = $urandom; exp1.push_back(a1 * b1); end
        else req1 = 1'b0;
      end
      prev_req0 = req0; prev_ack0 = ack0;
    end
    span = last_iss - first_iss + 1;
    chk("stream_results_r0", got0, want0);
    chk("stream_results_r1", got1, want1);
  endtask

  // Scoreboard entry: cycle in which U_VALID is high for the op, owner, result.
  typedef struct {
    int           u;
    logic         owner;
    logic [N-1:0] val;
  } iss_t;

  initial begin
    iss_t         q [$];
    logic [1:0]   e_ack, e_rv;
    logic         e_uv, e_sel, ptr, el0, el1, w;
    logic [N-1:0] e_ua, e_ub, e_res;
    int           e_pend, cnt, bad;
    int           n_iss, span, alt_bad, gap_bad, max_pend;

    tbl[0]  = mkv(0,1,0, 3,5,0,0,  0,0,0,0,0,0, 0,0,0,  0);
    tbl[1]  = mkv(0,1,0, 3,5,0,0,  0,0,0,0,0,0, 0,0,0,  0);
    tbl[2]  = mkv(1,1,0, 3,5,0,0,  1,0,1,0,0,0, 3,5,0,  0);
    tbl[3]  = mkv(1,0,0, 3,5,0,0,  0,0,0,0,0,0, 3,5,0,  1);
    tbl[4]  = mkv(1,0,0, 3,5,0,0,  0,0,0,0,0,0, 3,5,0,  1);
    tbl[5]  = mkv(1,0,0, 3,5,0,0,  0,0,0,0,0,0, 3,5,0,  1);
    tbl[6]  = mkv(1,0,0, 3,5,0,0,  0,0,0,0,0,0, 3,5,0,  1);
    tbl[7]  = mkv(1,0,0, 3,5,0,0,  0,0,0,0,1,0, 3,5,15, 0);
    tbl[8]  = mkv(1,0,1, 3,5,7,9,  0,1,1,1,0,0, 7,9,15, 0);
    tbl[9]  = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,0, 7,9,15, 1);
    tbl[10] = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,0, 7,9,15, 1);
    tbl[11] = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,0, 7,9,15, 1);
    tbl[12] = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,0, 7,9,15, 1);
    tbl[13] = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,1, 7,9,63, 0);
    tbl[14] = mkv(1,0,0, 3,5,7,9,  0,0,0,1,0,0, 7,9,63, 0);

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);

    // Reset and single operations from each requester.
    for (int i = 0; i < NV; i++) begin
      rst_n = tbl[i].rst_n; req0 = tbl[i].r0; req1 = tbl[i].r1;
      a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      tick();
      chk($sformatf("vec%0d_ack0", i), ack0, tbl[i].ack0);
      chk($sformatf("vec%0d_ack1", i), ack1, tbl[i].ack1);
      chk($sformatf("vec%0d_u_valid", i), u_valid, tbl[i].uv);
      chk($sformatf("vec%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("vec%0d_u_a", i), u_a, tbl[i].ua);
      chk($sformatf("vec%0d_u_b", i), u_b, tbl[i].ub);
      chk($sformatf("vec%0d_rv0", i), rv0, tbl[i].rv0);
      chk($sformatf("vec%0d_rv1", i), rv1, tbl[i].rv1);
      chk($sformatf("vec%0d_res", i), res, tbl[i].res);
      chk($sformatf("vec%0d_pend", i), pend, tbl[i].pend);
    end

    // Contention: both requesters, 8 operations each.
    run_stream(8, 8, n_iss, span, alt_bad, gap_bad, max_pend);
    chk("contention_issues", n_iss, 16);
    chk("contention_back_to_back", span, 16);
    chk("contention_alternation", alt_bad, 0);
    $display("contention: issues=%0d span=%0d alt_bad=%0d", n_iss, span, alt_bad);

    // Single continuous requester 1, 6 operations.
    run_stream(0, 6, n_iss, span, alt_bad, gap_bad, max_pend);
    chk("single_issues", n_iss, 6);
    chk("single_span", span, 11);
    chk("single_ack_every_other", gap_bad, 0);
    chk("single_pend_le3", max_pend <= 3, 1'b1);
    chk("single_pend_peak", max_pend, 2);
    $display("single: issues=%0d span=%0d max_pend=%0d", n_iss, span, max_pend);

    // Both continuously requesting, 6 each (fixed priority check inside).
    run_stream(6, 6, n_iss, span, alt_bad, gap_bad, max_pend);
    chk("both6_issues", n_iss, 12);
    chk("both6_alternation", alt_bad, 0);
    $display("both6: issues=%0d alt_bad=%0d", n_iss, alt_bad);

    // Reset while three operations are in flight.
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      tick();
      if (ack0) begin cnt++; a0 = $urandom; end
      if (ack1) begin cnt++; a1 = $urandom; end
      if (cnt >= 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("rst_mid_issued", cnt, 3);
    tick();
    chk("rst_mid_pend_before", pend, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 2 * LAT + 2; c++) begin
      if (rv0 || rv1) bad++;
      if (pend != 5'd0) bad++;
      tick();
    end
    chk("rst_mid_no_results", bad, 0);
    chk("rst_mid_res", res, 0);
    $display("reset mid-flight: issued=%0d violations=%0d", cnt, bad);

    // Randomized run against the scoreboard (occasional resets included).
    q.delete();
    e_ack = 2'b00; e_uv = 1'b0; e_sel = 1'b0; e_ua = '0; e_ub = '0; e_res = '0; ptr = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin
        e_rv = 2'b00; e_pend = 0;
        while (q.size() > 0 && q[0].u < k - LAT - 1) void'(q.pop_front());
        foreach (q[i]) begin
          if (q[i].u == k - LAT - 1) begin e_rv[q[i].owner] = 1'b1; e_res = q[i].val; end
          if (q[i].u >= k - LAT && q[i].u <= k - 1) e_pend++;
        end
        chk($sformatf("rnd%0d_ack0", k), ack0, e_ack[0]);
        chk($sformatf("rnd%0d_ack1", k), ack1, e_ack[1]);
        chk($sformatf("rnd%0d_u_valid", k), u_valid, e_uv);
        chk($sformatf("rnd%0d_sel", k), sel, e_sel);
        chk($sformatf("rnd%0d_u_a", k), u_a, e_ua);
        chk($sformatf("rnd%0d_u_b", k), u_b, e_ub);
        chk($sformatf("rnd%0d_rv0", k), rv0, e_rv[0]);
        chk($sformatf("rnd%0d_rv1", k), rv1, e_rv[1]);
        chk($sformatf("rnd%0d_res", k), res, e_res);
        chk($sformatf("rnd%0d_pend", k), pend, e_pend);
      end
      rst_n = (k == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
      if (!req0 || ack0) begin req0 = ($urandom_range(0, 3) != 0); a0 = $urandom; b0 = $urandom; end
      if (!req1 || ack1) begin req1 = ($urandom_range(0, 3) != 0); a1 = $urandom; b1 = $urandom; end
      if (!rst_n) begin
        q.delete();
        e_ack = 2'b00; e_uv = 1'b0; e_sel = 1'b0; e_ua = '0; e_ub = '0; e_res = '0; ptr = 1'b0;
      end else begin
        el0 = req0 && !e_ack[0];
        el1 = req1 && !e_ack[1];
        e_ack = 2'b00;
        e_uv = el0 || el1;
        if (e_uv) begin
          if (el0 && el1) w = FIXED_PRIO ? 1'b0 : ptr;
          else w = el1;
          ptr = !w;
          e_ack[w] = 1'b1;
          e_sel = w;
          e_ua = w ? a1 : a0;
          e_ub = w ? b1 : b0;
          q.push_back('{k + 1, w, e_ua * e_ub});
        end
      end
      tick();
    end
    $display("random: 600 cycles done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
